// File: rtl/hazard1_muldiv_pkg.sv
// Shared definitions for the hazard1 iterative multiply/divide unit:
// RV32M funct3 encodings and the sequencer state encoding.
package hazard1_muldiv_pkg;

    localparam logic [2:0] RV_FUNCT3_MUL    = 3'd0;
    localparam logic [2:0] RV_FUNCT3_MULH   = 3'd1;
    localparam logic [2:0] RV_FUNCT3_MULHSU = 3'd2;
    localparam logic [2:0] RV_FUNCT3_MULHU  = 3'd3;
    localparam logic [2:0] RV_FUNCT3_DIV    = 3'd4;
    localparam logic [2:0] RV_FUNCT3_DIVU   = 3'd5;
    localparam logic [2:0] RV_FUNCT3_REM    = 3'd6;
    localparam logic [2:0] RV_FUNCT3_REMU   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/hazard1_muldiv_step.sv
// One combinational radix-2 step: shift-add for multiply, or
// compare/subtract (restoring) for divide with acc = {remainder, quotient}.
module hazard1_muldiv_step #(
    parameter int W_DATA = 32
) (
    input  logic                  is_div,
    input  logic [2*W_DATA-1:0]   acc_cur,
    input  logic [2*W_DATA-1:0]   mcand_cur,
    input  logic [W_DATA-1:0]     mplier_cur,
    output logic [2*W_DATA-1:0]   acc_nxt,
    output logic [2*W_DATA-1:0]   mcand_nxt,
    output logic [W_DATA-1:0]     mplier_nxt
);

    logic [W_DATA:0] rem_sh;
    logic [W_DATA:0] rem_sub;
    logic            ge;

    always_comb begin
        // Divisor lives in the low half of the multiplicand register.
        rem_sh  = {acc_cur[2*W_DATA-1:W_DATA], acc_cur[W_DATA-1]};
        ge      = rem_sh >= {1'b0, mcand_cur[W_DATA-1:0]};
        rem_sub = rem_sh - {1'b0, mcand_cur[W_DATA-1:0]};
        if (is_div) begin
            acc_nxt    = {(ge ? rem_sub[W_DATA-1:0] : rem_sh[W_DATA-1:0]),
                          acc_cur[W_DATA-2:0], ge};
            mcand_nxt  = mcand_cur;
            mplier_nxt = mplier_cur;
        end else begin
            acc_nxt    = mplier_cur[0] ? (acc_cur + mcand_cur) : acc_cur;
            mcand_nxt  = mcand_cur << 1;
            mplier_nxt = mplier_cur >> 1;
        end
    end

endmodule

// File: rtl/hazard1_muldiv_seq.sv
// Iterative RV32M multiply/divide unit, UNROLL radix-2 steps per cycle.
// Optional HAZARD1_MULDIV_EARLY_TERM_EN: finish multiplies once the multiplier is exhausted.
module hazard1_muldiv_seq
    import hazard1_muldiv_pkg::*;
#(
    parameter int W_DATA = 32,
    parameter int UNROLL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_vld,
    output logic              op_rdy,
    input  logic [2:0]        op,
    input  logic [W_DATA-1:0] op_a,
    input  logic [W_DATA-1:0] op_b,
    input  logic              op_kill,
    output logic              result_vld,
    input  logic              result_rdy,
    output logic [W_DATA-1:0] result
);

    localparam int N     = W_DATA / UNROLL;
    localparam int CNT_W = $clog2(N) + 1;

    state_t                state_reg, state_next;
    logic [2:0]            op_reg;
    logic [2*W_DATA-1:0]   acc_reg, mcand_reg;
    logic [W_DATA-1:0]     mplier_reg;
    logic                  neg_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [W_DATA-1:0]     result_reg;

    logic [2*W_DATA-1:0]   acc_chain    [UNROLL+1];
    logic [2*W_DATA-1:0]   mcand_chain  [UNROLL+1];
    logic [W_DATA-1:0]     mplier_chain [UNROLL+1];

    logic                  accept, done_now;
    logic                  a_signed, b_signed, sa, sb, neg_load;
    logic [W_DATA-1:0]     a_mag, b_mag;
    logic [2*W_DATA-1:0]   full, prod;
    logic [W_DATA-1:0]     quot, rem, res_final;

    assign op_rdy     = !op_kill && ((state_reg == S_IDLE) ||
                                     ((state_reg == S_DONE) && result_rdy));
    assign accept     = op_vld && op_rdy;
    assign result_vld = (state_reg == S_DONE);
    assign result     = result_reg;

    assign acc_chain[0]    = acc_reg;
    assign mcand_chain[0]  = mcand_reg;
    assign mplier_chain[0] = mplier_reg;

    generate
        for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
            hazard1_muldiv_step #(.W_DATA(W_DATA)) u_step (
                .is_div     (op_reg[2]),
                .acc_cur    (acc_chain[gi]),
                .mcand_cur  (mcand_chain[gi]),
                .mplier_cur (mplier_chain[gi]),
                .acc_nxt    (acc_chain[gi+1]),
                .mcand_nxt  (mcand_chain[gi+1]),
                .mplier_nxt (mplier_chain[gi+1])
            );
        end
    endgenerate

    // Operand magnitudes and the single result-negation flag for this op.
    always_comb begin
        a_signed = !((op == RV_FUNCT3_MULHU) || (op == RV_FUNCT3_DIVU) ||
                     (op == RV_FUNCT3_REMU));
        b_signed = (op == RV_FUNCT3_MUL) || (op == RV_FUNCT3_MULH) ||
                   (op == RV_FUNCT3_DIV) || (op == RV_FUNCT3_REM);
        sa       = a_signed && op_a[W_DATA-1];
        sb       = b_signed && op_b[W_DATA-1];
        a_mag    = sa ? -op_a : op_a;
        b_mag    = sb ? -op_b : op_b;
        if (!op[2])
            neg_load = sa ^ sb;
        else if (!op[1])
            neg_load = (sa ^ sb) && (op_b != '0);
        else
            neg_load = sa;
    end

    always_comb begin
        full = acc_chain[UNROLL];
        prod = neg_reg ? -full : full;
        quot = neg_reg ? -full[W_DATA-1:0] : full[W_DATA-1:0];
        rem  = neg_reg ? -full[2*W_DATA-1:W_DATA] : full[2*W_DATA-1:W_DATA];
        case (op_reg)
            RV_FUNCT3_MUL:                   res_final = prod[W_DATA-1:0];
            RV_FUNCT3_DIV, RV_FUNCT3_DIVU:   res_final = quot;
            RV_FUNCT3_REM, RV_FUNCT3_REMU:   res_final = rem;
            default:                         res_final = prod[2*W_DATA-1:W_DATA];
        endcase
    end

    always_comb begin
        done_now = (cnt_reg == '0);
`ifdef HAZARD1_MULDIV_EARLY_TERM_EN
        if (!op_reg[2] && (mplier_chain[UNROLL] == '0))
            done_now = 1'b1;
`endif
    end

    // Kill overrides everything, including a back-to-back accept.
    always_comb begin
        state_next = state_reg;
        if (op_kill) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (op_vld) state_next = S_RUN;
                S_RUN:   if (done_now) state_next = S_DONE;
                S_DONE:  if (result_rdy) state_next = op_vld ? S_RUN : S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            neg_reg    <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg  <= op;
                neg_reg <= neg_load;
                cnt_reg <= CNT_W'(N - 1);
                if (op[2]) begin
                    acc_reg    <= {{W_DATA{1'b0}}, a_mag};
                    mcand_reg  <= {{W_DATA{1'b0}}, b_mag};
                    mplier_reg <= '0;
                end else begin
                    acc_reg    <= '0;
                    mcand_reg  <= {{W_DATA{1'b0}}, a_mag};
                    mplier_reg <= b_mag;
                end
            end else if (state_reg == S_RUN) begin
                acc_reg    <= acc_chain[UNROLL];
                mcand_reg  <= mcand_chain[UNROLL];
                mplier_reg <= mplier_chain[UNROLL];
                cnt_reg    <= cnt_reg - CNT_W'(1);
            end
            if ((state_reg == S_RUN) && (state_next == S_DONE))
                result_reg <= res_final;
        end
    end

endmodule

// File: tb/tb_hazard1_muldiv_seq.sv
// Scoreboard bench for hazard1_muldiv_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_hazard1_muldiv_seq;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_vld, op_rdy, op_kill, result_vld, result_rdy;
    logic [2:0]  op;
    logic [31:0] op_a, op_b, result;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    hazard1_muldiv_seq #(.W_DATA(32), .UNROLL(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_vld     (op_vld),
        .op_rdy     (op_rdy),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_kill    (op_kill),
        .result_vld (result_vld),
        .result_rdy (result_rdy),
        .result     (result)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    endtask

    // Monitor: one line per retired result.
    initial begin
        string       nm;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && result_vld && result_rdy) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_result: got %08h, expected no result", result);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    $display("result %s = %08h", nm, result);
                    check(nm, result, e);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input string nm, input bit push);
        int n;
        op = o; op_a = a; op_b = b; op_vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (!op_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!op_rdy) begin
            total_cnt++;
            $display("FAIL issue_timeout %s: got op_rdy=0, expected 1", nm);
        end
        if (push) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        $display("issue %s op=%0d a=%08h b=%08h", nm, o, a, b);
        @(posedge clk); #1;
        op_vld = 1'b0;
    endtask

    // Cycle index (accept cycle = 0) at which result_vld is first seen.
    task automatic wait_vld(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!result_vld && cyc < 100);
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input string nm);
        int c;
        issue(o, a, b, e, nm, 1'b1);
        wait_vld(c);
        if (!result_vld) begin
            total_cnt++;
            $display("FAIL %s_timeout: got result_vld=0, expected 1", nm);
        end
        @(posedge clk); #1;
    endtask

    logic [2:0]  v_op [11] = '{F_MULH, F_MULHSU, F_MULHU, F_DIV, F_REM, F_DIVU,
                               F_REM, F_DIV, F_REM, F_REMU, F_MUL};
    logic [31:0] v_a  [11] = '{32'h80000000, 32'hffffffff, 32'hffffffff, 32'h80000000,
                               32'h80000000, 32'd5, 32'hfffffffb, 32'hfffffff9,
                               32'hfffffff9, 32'd100, 32'h12345678};
    logic [31:0] v_b  [11] = '{32'h80000000, 32'hffffffff, 32'hffffffff, 32'hffffffff,
                               32'hffffffff, 32'd0, 32'd0, 32'd2, 32'd2, 32'd7, 32'h10};
    logic [31:0] v_e  [11] = '{32'h40000000, 32'hffffffff, 32'hfffffffe, 32'h80000000,
                               32'h00000000, 32'hffffffff, 32'hfffffffb, 32'hfffffffd,
                               32'hffffffff, 32'd2, 32'h23456780};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        bit  seen;
        rst = 1'b1; op_vld = 1'b0; op = '0; op_a = '0; op_b = '0;
        op_kill = 1'b0; result_rdy = 1'b1;
        #12;
        check("reset_op_rdy", {31'b0, op_rdy}, 32'd1);
        check("reset_result_vld", {31'b0, result_vld}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency and op_rdy in the first DONE cycle.
        issue(F_MUL, 32'd7, 32'hfffffffd, 32'hffffffeb, "mul_7x-3", 1'b1);
        wait_vld(c);
        check("mul_latency", c, 32'd33);
        check("mul_op_rdy_at_vld", {31'b0, op_rdy}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++)
            run(v_op[i], v_a[i], v_b[i], v_e[i], $sformatf("vec%0d", i));

        // Kill in IDLE blocks acceptance.
        op = F_MUL; op_a = 32'd2; op_b = 32'd3; op_kill = 1'b1; op_vld = 1'b1;
        @(negedge clk);
        check("kill_idle_op_rdy", {31'b0, op_rdy}, 32'd0);
        @(posedge clk); #1;
        op_kill = 1'b0; op_vld = 1'b0;
        @(negedge clk);
        check("kill_idle_not_accepted", {31'b0, op_rdy}, 32'd1);
        @(posedge clk); #1;

        // Kill a DIV at cycle 10.
        issue(F_DIV, 32'd100, 32'd7, 32'd0, "div_killed", 1'b0);
        repeat (9) @(posedge clk);
        #1 op_kill = 1'b1;
        @(posedge clk); #1;
        op_kill = 1'b0;
        @(negedge clk);
        check("kill_run_idle_rdy", {31'b0, op_rdy}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= result_vld;
        end
        check("kill_no_result_vld", {31'b0, seen}, 32'd0);
        @(posedge clk); #1;
        run(F_DIV, 32'd100, 32'd7, 32'd14, "div_after_kill");

        // Asynchronous reset mid-RUN.
        issue(F_MUL, 32'd3, 32'd4, 32'd0, "mul_reset", 1'b0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_op_rdy", {31'b0, op_rdy}, 32'd1);
        check("async_rst_result_vld", {31'b0, result_vld}, 32'd0);
        check("async_rst_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run(F_MUL, 32'd3, 32'd4, 32'd12, "mul_after_rst");

        // Hold result while result_rdy is low, then back-to-back handoff.
        result_rdy = 1'b0;
        issue(F_DIV, 32'd100, 32'd7, 32'd14, "div_hold", 1'b1);
        wait_vld(c);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_result_%0d", i), result, 32'd14);
            check($sformatf("hold_vld_%0d", i), {31'b0, result_vld}, 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        result_rdy = 1'b1;
        issue(F_REMU, 32'd100, 32'd7, 32'd2, "remu_b2b", 1'b1);
        @(negedge clk);
        check("b2b_new_op_running", {31'b0, result_vld}, 32'd0);
        wait_vld(c);
        @(posedge clk); #1;

`ifdef HAZARD1_MULDIV_EARLY_TERM_EN
        issue(F_MUL, 32'd5, 32'd1, 32'd5, "mul_early", 1'b1);
        wait_vld(c);
        check("early_term_latency", c, 32'd2);
        @(posedge clk); #1;
        issue(F_MUL, 32'd3, 32'h80000000, 32'h80000000, "mul_full", 1'b1);
        wait_vld(c);
        check("full_latency", c, 32'd33);
        @(posedge clk); #1;
`else
        issue(F_MUL, 32'd5, 32'd1, 32'd5, "mul_fixed", 1'b1);
        wait_vld(c);
        check("fixed_latency", c, 32'd33);
        @(posedge clk); #1;
`endif

        c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
